// File: rtl/div_pkg.sv
// Shared types and constants for the multi-cycle RV32M divider.
package div_pkg;

  typedef enum logic [1:0] {
    DIV  = 2'b00,
    DIVU = 2'b01,
    REM  = 2'b10,
    REMU = 2'b11
  } div_op_e;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    CALC = 2'b01,
    DONE = 2'b10
  } div_state_e;

  localparam logic [31:0] DIV_ZERO_Q = 32'hFFFF_FFFF;
  localparam logic [31:0] OVF_Q      = 32'h8000_0000;
  localparam logic [31:0] INT_MIN    = 32'h8000_0000;

endpackage

// File: rtl/div_step.sv
// One radix-2 restoring division step: shift in a dividend bit, trial-subtract the divisor.
module div_step #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] rem,
  input  logic             din,
  input  logic [WIDTH-1:0] divisor_mag,
  output logic [WIDTH-1:0] rem_next,
  output logic             q_bit
);

  logic [WIDTH:0] rem_tmp;
  logic [WIDTH:0] diff;

  always_comb begin
    rem_tmp = {rem, din};
    diff    = rem_tmp - {1'b0, divisor_mag};
    // A borrow out of the top bit means the trial subtract went negative; restore.
    q_bit   = ~diff[WIDTH];
    rem_next = q_bit ? diff[WIDTH-1:0] : rem_tmp[WIDTH-1:0];
  end

endmodule

// File: rtl/seq_divider32.sv
// Sequential 32-bit divider for DIV/DIVU/REM/REMU: one quotient bit per clock,
// with a single-cycle fast path for divide-by-zero and signed overflow.
module seq_divider32
  import div_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_start,
  input  logic [1:0]       i_op,
  input  logic [WIDTH-1:0] i_dividend,
  input  logic [WIDTH-1:0] i_divisor,
  output logic             o_busy,
  output logic             o_valid,
  output logic [WIDTH-1:0] o_result
);

  div_state_e       state;
  logic [CNT_W-1:0] cnt;
  logic [WIDTH-1:0] rem_q;
  logic [WIDTH-1:0] quo_q;
  logic [WIDTH-1:0] dmag_q;
  logic             is_rem_q;
  logic             neg_q_q;
  logic             neg_r_q;

  logic [WIDTH-1:0] step_rem;
  logic             step_q;
  logic [WIDTH-1:0] quo_next;

  div_op_e          op_in;
  logic             op_signed;
  logic             a_neg;
  logic             b_neg;
  logic             div_zero;
  logic             sgn_ovf;
  logic [WIDTH-1:0] fast_res;
  logic [WIDTH-1:0] final_res;

  // Two's-complement negate when en is set; used for operand magnitudes and sign fix-up.
  function automatic logic [WIDTH-1:0] cond_neg(input logic [WIDTH-1:0] v, input logic en);
    logic signed [WIDTH-1:0] sv;
    sv = v;
    return en ? -sv : v;
  endfunction

  div_step #(.WIDTH(WIDTH)) u_step (
    .rem         (rem_q),
    .din         (quo_q[WIDTH-1]),
    .divisor_mag (dmag_q),
    .rem_next    (step_rem),
    .q_bit       (step_q)
  );

  always_comb begin
    op_in     = div_op_e'(i_op);
    op_signed = (op_in == DIV) || (op_in == REM);
    a_neg     = op_signed & i_dividend[WIDTH-1];
    b_neg     = op_signed & i_divisor[WIDTH-1];
    div_zero  = (i_divisor == '0);
    sgn_ovf   = op_signed && (i_dividend == INT_MIN) && (i_divisor == '1);
    if (div_zero) fast_res = i_op[1] ? i_dividend : DIV_ZERO_Q;
    else          fast_res = i_op[1] ? '0 : OVF_Q;
    quo_next  = {quo_q[WIDTH-2:0], step_q};
    final_res = is_rem_q ? cond_neg(step_rem, neg_r_q) : cond_neg(quo_next, neg_q_q);
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state    <= IDLE;
      cnt      <= '0;
      rem_q    <= '0;
      quo_q    <= '0;
      dmag_q   <= '0;
      is_rem_q <= 1'b0;
      neg_q_q  <= 1'b0;
      neg_r_q  <= 1'b0;
      o_busy   <= 1'b0;
      o_valid  <= 1'b0;
      o_result <= '0;
    end else begin
      case (state)
        IDLE: begin
          o_valid <= 1'b0;
          if (i_start) begin
            o_busy   <= 1'b1;
            is_rem_q <= i_op[1];
            neg_q_q  <= a_neg ^ b_neg;
            neg_r_q  <= a_neg;
            if (div_zero || sgn_ovf) begin
              o_result <= fast_res;
              o_valid  <= 1'b1;
              state    <= DONE;
            end else begin
              rem_q  <= '0;
              quo_q  <= cond_neg(i_dividend, a_neg);
              dmag_q <= cond_neg(i_divisor, b_neg);
              cnt    <= CNT_W'(WIDTH);
              state  <= CALC;
            end
          end
        end
        // Dividend bits shift out of quo_q's MSB while quotient bits shift into its LSB.
        CALC: begin
          rem_q <= step_rem;
          quo_q <= quo_next;
          cnt   <= cnt - 1'b1;
          if (cnt == CNT_W'(1)) begin
            o_result <= final_res;
            o_valid  <= 1'b1;
            state    <= DONE;
          end
        end
        DONE: begin
          o_valid <= 1'b0;
          o_busy  <= 1'b0;
          state   <= IDLE;
        end
        default: begin
          o_valid <= 1'b0;
          o_busy  <= 1'b0;
          state   <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_seq_divider32.sv
// Directed bench for seq_divider32: results, latency, busy window, fast paths and reset abort.
module tb_seq_divider32;

  logic        i_clk;
  logic        i_rst_n;
  logic        i_start;
  logic [1:0]  i_op;
  logic [31:0] i_dividend;
  logic [31:0] i_divisor;
  logic        o_busy;
  logic        o_valid;
  logic [31:0] o_result;

  int n_checks = 0;
  int n_fail   = 0;

  seq_divider32 #(.WIDTH(32), .CNT_W(6)) dut (
    .i_clk      (i_clk),
    .i_rst_n    (i_rst_n),
    .i_start    (i_start),
    .i_op       (i_op),
    .i_dividend (i_dividend),
    .i_divisor  (i_divisor),
    .o_busy     (o_busy),
    .o_valid    (o_valid),
    .o_result   (o_result)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Issue one operation and observe it for 40 cycles; cycle 1 is the period after the start edge.
  // glitch > 0 raises a stray i_start with other operands for that single cycle.
  task automatic run_op(input string tag, input logic [1:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp, input int exp_lat,
                        input int glitch);
    int lat, vcnt, bcnt;
    logic [31:0] res;
    lat = 0; vcnt = 0; bcnt = 0; res = 32'h0;
    @(negedge i_clk);
    i_op = op; i_dividend = a; i_divisor = b; i_start = 1'b1;
    @(posedge i_clk);
    #1 i_start = 1'b0;
    for (int c = 1; c <= 40; c++) begin
      @(negedge i_clk);
      if (o_valid) begin
        if (vcnt == 0) begin
          lat = c;
          res = o_result;
        end
        vcnt++;
      end
      if (o_busy) bcnt++;
      if (c == glitch) begin
        i_start = 1'b1; i_op = 2'b00; i_dividend = 32'd50; i_divisor = 32'd5;
      end else if (c == glitch + 1) begin
        i_start = 1'b0; i_dividend = 32'hDEAD_BEEF; i_divisor = 32'd3;
      end
    end
    check_eq({tag, " result"}, res, exp);
    check_eq({tag, " latency"}, lat, exp_lat);
    check_eq({tag, " valid pulses"}, vcnt, 1);
    check_eq({tag, " busy cycles"}, bcnt, exp_lat);
    check_eq({tag, " held"}, o_result, exp);
  endtask

  initial begin
    int vcnt, bcnt;
    i_rst_n = 1'b0; i_start = 1'b0; i_op = 2'b00; i_dividend = '0; i_divisor = '0;
    repeat (3) @(negedge i_clk);
    check_eq("reset busy", o_busy, 0);
    check_eq("reset valid", o_valid, 0);
    check_eq("reset result", o_result, 0);
    i_rst_n = 1'b1;
    @(negedge i_clk);

    run_op("divu 100/7",  2'b01, 32'd100, 32'd7, 32'd14, 33, 0);
    run_op("remu 100/7",  2'b11, 32'd100, 32'd7, 32'd2,  33, 0);
    run_op("div -7/2",    2'b00, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 33, 0);
    run_op("rem -7/2",    2'b10, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 33, 0);
    run_op("div 7/-2",    2'b00, 32'd7, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 33, 0);
    run_op("rem 7/-2",    2'b10, 32'd7, 32'hFFFF_FFFE, 32'd1, 33, 0);
    run_op("divu x/0",    2'b01, 32'h1234, 32'd0, 32'hFFFF_FFFF, 1, 0);
    run_op("remu x/0",    2'b11, 32'h1234, 32'd0, 32'h1234, 1, 0);
    run_op("div -7/0",    2'b00, 32'hFFFF_FFF9, 32'd0, 32'hFFFF_FFFF, 1, 0);
    run_op("rem -7/0",    2'b10, 32'hFFFF_FFF9, 32'd0, 32'hFFFF_FFF9, 1, 0);
    run_op("div ovf",     2'b00, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1, 0);
    run_op("rem ovf",     2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 1, 0);
    run_op("divu min/-1", 2'b01, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 33, 0);
    run_op("remu min/-1", 2'b11, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 33, 0);
    run_op("div min/1",   2'b00, 32'h8000_0000, 32'd1, 32'h8000_0000, 33, 0);
    run_op("divu max/1 glitch", 2'b01, 32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFFF, 33, 5);
    run_op("remu max/1 glitch", 2'b11, 32'hFFFF_FFFF, 32'd1, 32'd0, 33, 5);
    run_op("divu start in done", 2'b01, 32'd100, 32'd7, 32'd14, 33, 33);

    // Abort DIVU 1000/3 with reset in cycle 10.
    @(negedge i_clk);
    i_op = 2'b01; i_dividend = 32'd1000; i_divisor = 32'd3; i_start = 1'b1;
    @(posedge i_clk);
    #1 i_start = 1'b0;
    repeat (10) @(negedge i_clk);
    i_rst_n = 1'b0;
    #1;
    check_eq("abort busy", o_busy, 0);
    check_eq("abort valid", o_valid, 0);
    check_eq("abort result", o_result, 0);
    @(negedge i_clk);
    i_rst_n = 1'b1;
    vcnt = 0; bcnt = 0;
    for (int c = 0; c < 40; c++) begin
      @(negedge i_clk);
      if (o_valid) vcnt++;
      if (o_busy) bcnt++;
    end
    check_eq("abort no valid", vcnt, 0);
    check_eq("abort no busy", bcnt, 0);
    check_eq("abort result held", o_result, 0);

    run_op("divu 1000/3", 2'b01, 32'd1000, 32'd3, 32'd333, 33, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, checks %0d failures %0d", n_checks, n_fail);
    $fatal(1);
  end

endmodule
